// File: rtl/sap1_uc_pkg.sv
// Shared definitions for the SAP-1 microprogram sequencer: control-word bit
// positions, the idle control word, opcodes, routine start addresses, the
// per-word sequencing action and the sequencer state encoding.
package sap1_uc_pkg;

  localparam int UADDR_W = 5;   // micro-PC width (32 control-store words)
  localparam int CW_W    = 17;  // control word width
  localparam int OP_W    = 4;   // opcode width (IR[7:4])

  // Control word bit positions, MSB first: EP CP LM* CE* LI* EI CS LOAD CLR INC LA* EA LB* SU AD EU LO*
  localparam int CW_EP   = 16;
  localparam int CW_CP   = 15;
  localparam int CW_LM   = 14;  // active low
  localparam int CW_CE   = 13;  // active low
  localparam int CW_LI   = 12;  // active low
  localparam int CW_EI   = 11;
  localparam int CW_CS   = 10;
  localparam int CW_LOAD = 9;
  localparam int CW_CLR  = 8;
  localparam int CW_INC  = 7;
  localparam int CW_LA   = 6;   // active low
  localparam int CW_EA   = 5;
  localparam int CW_LB   = 4;   // active low
  localparam int CW_SU   = 3;
  localparam int CW_AD   = 2;
  localparam int CW_EU   = 1;
  localparam int CW_LO   = 0;   // active low

  // Single-bit masks so store words can be written as edits of CW_IDLE
  localparam logic [CW_W-1:0] M_EP   = CW_W'(1) << CW_EP;
  localparam logic [CW_W-1:0] M_CP   = CW_W'(1) << CW_CP;
  localparam logic [CW_W-1:0] M_LM   = CW_W'(1) << CW_LM;
  localparam logic [CW_W-1:0] M_CE   = CW_W'(1) << CW_CE;
  localparam logic [CW_W-1:0] M_LI   = CW_W'(1) << CW_LI;
  localparam logic [CW_W-1:0] M_EI   = CW_W'(1) << CW_EI;
  localparam logic [CW_W-1:0] M_CS   = CW_W'(1) << CW_CS;
  localparam logic [CW_W-1:0] M_LOAD = CW_W'(1) << CW_LOAD;
  localparam logic [CW_W-1:0] M_CLR  = CW_W'(1) << CW_CLR;
  localparam logic [CW_W-1:0] M_INC  = CW_W'(1) << CW_INC;
  localparam logic [CW_W-1:0] M_LA   = CW_W'(1) << CW_LA;
  localparam logic [CW_W-1:0] M_EA   = CW_W'(1) << CW_EA;
  localparam logic [CW_W-1:0] M_LB   = CW_W'(1) << CW_LB;
  localparam logic [CW_W-1:0] M_SU   = CW_W'(1) << CW_SU;
  localparam logic [CW_W-1:0] M_AD   = CW_W'(1) << CW_AD;
  localparam logic [CW_W-1:0] M_EU   = CW_W'(1) << CW_EU;
  localparam logic [CW_W-1:0] M_LO   = CW_W'(1) << CW_LO;

  // Bits owned by the sequencing action rather than by the store word
  localparam logic [CW_W-1:0] SEQ_MASK = M_CS | M_LOAD | M_CLR | M_INC;

  // All loads inactive, LO* high, nothing driving the bus
  localparam logic [CW_W-1:0] CW_IDLE = 17'h07051;

  // Opcodes (IR upper nibble)
  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Control-store routine start addresses
  localparam logic [UADDR_W-1:0] UA_FETCH = 5'd0;
  localparam logic [UADDR_W-1:0] UA_MAP   = 5'd3;
  localparam logic [UADDR_W-1:0] UA_LDA   = 5'd4;
  localparam logic [UADDR_W-1:0] UA_ADD   = 5'd7;
  localparam logic [UADDR_W-1:0] UA_SUB   = 5'd12;
  localparam logic [UADDR_W-1:0] UA_OUT   = 5'd17;
  localparam logic [UADDR_W-1:0] UA_HLT   = 5'd20;
  localparam logic [UADDR_W-1:0] UA_NOP   = 5'd21;

  // What the sequencer does after the current micro-step
  typedef enum logic [1:0] {
    ACT_INC  = 2'd0,
    ACT_MAP  = 2'd1,
    ACT_RET  = 2'd2,
    ACT_HALT = 2'd3
  } action_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/sap1_map_rom.sv
// Opcode-to-routine mapping ROM: returns the control-store start address of
// the routine for an opcode and whether that opcode is implemented.
// Unimplemented opcodes fall through to the NOP routine.
module sap1_map_rom
  import sap1_uc_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  output logic [UADDR_W-1:0] start_addr,
  output logic               legal
);

  // Pure lookup; defaults describe the unmapped-opcode case
  always_comb begin
    start_addr = UA_NOP;
    legal      = 1'b0;
    case (opcode)
      OP_LDA: begin start_addr = UA_LDA; legal = 1'b1; end
      OP_ADD: begin start_addr = UA_ADD; legal = 1'b1; end
      OP_SUB: begin start_addr = UA_SUB; legal = 1'b1; end
      OP_OUT: begin start_addr = UA_OUT; legal = 1'b1; end
      OP_HLT: begin start_addr = UA_HLT; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap1_micro_sequencer.sv
// SAP-1 microprogram sequencer. A 32-word control store addressed by a 5-bit
// micro-PC produces the 17-bit control word; each store word also carries a
// sequencing action (increment, map on opcode, return to fetch, halt).
// Run / single-step / halt control sits around the micro-PC.
module sap1_micro_sequencer
  import sap1_uc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic [OP_W-1:0]    ir_opcode,
  output logic [CW_W-1:0]    cw,
  output logic [UADDR_W-1:0] upc,
  output logic               halted,
  output logic               instr_done,
  output logic               illegal
);

  state_t             state_reg;
  logic [UADDR_W-1:0] upc_reg;
  logic               single_reg;   // current instruction was started by step
  logic               illegal_reg;
  logic               halted_reg;

  logic [CW_W-1:0]    store_word;
  action_t            action;
  logic [UADDR_W-1:0] map_addr;
  logic               map_legal;

  sap1_map_rom u_map_rom (
    .opcode     (ir_opcode),
    .start_addr (map_addr),
    .legal      (map_legal)
  );

  // Control store and action table, indexed by the micro-PC.
  // The CS/LOAD/CLR/INC bits of the stored word are replaced by the action below.
  always_comb begin
    store_word = CW_IDLE;
    action     = ACT_RET;
    case (upc_reg)
      // fetch: PC -> MAR, PC+1, RAM -> IR, then map on opcode
      5'd0:  begin store_word = 17'b10011000011010001; action = ACT_INC; end
      5'd1:  begin store_word = 17'b01111000011010001; action = ACT_INC; end
      5'd2:  begin store_word = 17'b00100000011010001; action = ACT_INC; end
      5'd3:  begin store_word = 17'b00111011001010001; action = ACT_MAP; end
      // LDA: IR -> MAR, RAM -> A
      5'd4:  begin store_word = 17'b00011100011010001; action = ACT_INC; end
      5'd5:  begin store_word = 17'b00101000010010001; action = ACT_INC; end
      5'd6:  begin store_word = 17'b00111000101010001; action = ACT_RET; end
      // ADD: IR -> MAR, RAM -> B, add, ALU -> A
      5'd7:  begin store_word = (CW_IDLE & ~M_LM) | M_EI;   action = ACT_INC; end
      5'd8:  begin store_word = CW_IDLE & ~(M_CE | M_LB);   action = ACT_INC; end
      5'd9:  begin store_word = CW_IDLE | M_AD;             action = ACT_INC; end
      5'd10: begin store_word = (CW_IDLE & ~M_LA) | M_EU;   action = ACT_INC; end
      5'd11: begin store_word = CW_IDLE;                    action = ACT_RET; end
      // SUB: as ADD with subtract selected
      5'd12: begin store_word = (CW_IDLE & ~M_LM) | M_EI;   action = ACT_INC; end
      5'd13: begin store_word = CW_IDLE & ~(M_CE | M_LB);   action = ACT_INC; end
      5'd14: begin store_word = CW_IDLE | M_SU;             action = ACT_INC; end
      5'd15: begin store_word = (CW_IDLE & ~M_LA) | M_EU;   action = ACT_INC; end
      5'd16: begin store_word = CW_IDLE;                    action = ACT_RET; end
      // OUT: IR -> MAR (kept from the original routine), A -> output register
      5'd17: begin store_word = (CW_IDLE & ~M_LM) | M_EI;   action = ACT_INC; end
      5'd18: begin store_word = (CW_IDLE & ~M_LO) | M_EA;   action = ACT_INC; end
      5'd19: begin store_word = CW_IDLE;                    action = ACT_RET; end
      // HLT and NOP
      5'd20: begin store_word = CW_IDLE;                    action = ACT_HALT; end
      5'd21: begin store_word = CW_IDLE;                    action = ACT_RET; end
      // 22-31 are unused and return to fetch so the micro-PC never runs off the end
      default: ;
    endcase
  end

  // Control word and end-of-instruction strobe, decoded from state and micro-PC
  always_comb begin
    cw         = CW_IDLE;
    instr_done = 1'b0;
    if (state_reg == S_EXEC) begin
      cw = store_word & ~SEQ_MASK;
      case (action)
        ACT_INC:  cw = cw | M_INC;
        ACT_MAP:  cw = cw | M_CS | M_LOAD;
        ACT_RET:  begin cw = cw | M_CLR; instr_done = 1'b1; end
        ACT_HALT: instr_done = 1'b1;
      endcase
    end
  end

  // Sequencer FSM: micro-PC advance, run/step/halt control, sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      upc_reg     <= UA_FETCH;
      single_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // run wins over step when both are present
          if (run || step) begin
            state_reg  <= S_EXEC;
            upc_reg    <= UA_FETCH;
            single_reg <= ~run;
          end
        end
        S_EXEC: begin
          // step is deliberately not looked at here
          case (action)
            ACT_INC: upc_reg <= upc_reg + UADDR_W'(1);
            ACT_MAP: begin
              upc_reg <= map_addr;
              if (!map_legal) illegal_reg <= 1'b1;
            end
            ACT_RET: begin
              upc_reg <= UA_FETCH;
              // stop only on instruction boundaries; continuous run has no bubble
              if (single_reg || !run) state_reg <= S_IDLE;
            end
            ACT_HALT: begin
              state_reg  <= S_HALTED;
              halted_reg <= 1'b1;
              upc_reg    <= UA_HLT;
            end
          endcase
        end
        S_HALTED: begin
          // frozen until reset
          upc_reg <= UA_HLT;
        end
        default: begin
          state_reg <= S_IDLE;
          upc_reg   <= UA_FETCH;
        end
      endcase
    end
  end

  assign upc     = upc_reg;
  assign halted  = halted_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_sap1_micro_sequencer.sv
// Bench for sap1_micro_sequencer: directed scenarios followed by randomized
// run/step/opcode/reset traffic, all checked every cycle against an
// instruction-level reference model (queue of expected micro-steps).
module tb_sap1_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic [3:0]  ir_opcode;
  logic [16:0] cw;
  logic [4:0]  upc;
  logic        halted;
  logic        instr_done;
  logic        illegal;

  sap1_micro_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .ir_opcode  (ir_opcode),
    .cw         (cw),
    .upc        (upc),
    .halted     (halted),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] IDLE_WORD = 17'h07051;
  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_HALT = 2;

  typedef struct {
    int upc;
    bit last;
    bit halt;
    bit map;
  } ustep_t;

  ustep_t      m_q[$];
  logic [16:0] word_of [32];
  int          m_mode;
  bit          m_single;
  bit          m_illegal;
  logic [3:0]  m_op;
  int          m_len;
  int          n_instr;
  int          n_total;
  int          n_bad;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Expected emitted control words (sequencing bits included) per micro-address
  task automatic init_words();
    for (int i = 0; i < 32; i++) word_of[i] = 17'h07151;
    word_of[0]  = 17'h130D1;  word_of[1]  = 17'h0F0D1;
    word_of[2]  = 17'h040D1;  word_of[3]  = 17'h07651;
    word_of[4]  = 17'h038D1;  word_of[5]  = 17'h05091;  word_of[6]  = 17'h07151;
    word_of[7]  = 17'h038D1;  word_of[8]  = 17'h050C1;  word_of[9]  = 17'h070D5;
    word_of[10] = 17'h07093;  word_of[11] = 17'h07151;
    word_of[12] = 17'h038D1;  word_of[13] = 17'h050C1;  word_of[14] = 17'h070D9;
    word_of[15] = 17'h07093;  word_of[16] = 17'h07151;
    word_of[17] = 17'h038D1;  word_of[18] = 17'h070F0;  word_of[19] = 17'h07151;
    word_of[20] = 17'h07051;  word_of[21] = 17'h07151;
  endtask

  task automatic push_step(input int a, input bit last, input bit halt, input bit map);
    ustep_t s;
    s.upc = a; s.last = last; s.halt = halt; s.map = map;
    m_q.push_back(s);
  endtask

  task automatic push_fetch();
    push_step(0, 0, 0, 0);
    push_step(1, 0, 0, 0);
    push_step(2, 0, 0, 0);
    push_step(3, 0, 0, 1);
  endtask

  task automatic push_routine(input logic [3:0] op);
    case (op)
      4'h0: begin for (int a = 4; a <= 5; a++) push_step(a, 0, 0, 0); push_step(6, 1, 0, 0); end
      4'h1: begin for (int a = 7; a <= 10; a++) push_step(a, 0, 0, 0); push_step(11, 1, 0, 0); end
      4'h2: begin for (int a = 12; a <= 15; a++) push_step(a, 0, 0, 0); push_step(16, 1, 0, 0); end
      4'hE: begin push_step(17, 0, 0, 0); push_step(18, 0, 0, 0); push_step(19, 1, 0, 0); end
      4'hF: push_step(20, 1, 1, 0);
      default: begin push_step(21, 1, 0, 0); m_illegal = 1'b1; end
    endcase
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE; m_single = 1'b0; m_illegal = 1'b0; m_len = 0;
  endtask

  // One clock edge of the reference, given the inputs present at that edge
  task automatic model_advance(input logic r, input logic s, input logic [3:0] op);
    ustep_t cur;
    case (m_mode)
      M_IDLE: if (r || s) begin
        m_mode = M_EXEC; m_single = !r; m_len = 0;
        push_fetch();
      end
      M_EXEC: begin
        cur = m_q.pop_front();
        m_len++;
        if (cur.map) begin m_op = op; push_routine(op); end
        if (cur.last) begin
          n_instr++;
          $display("instr %0d: op=%h cycles=%0d", n_instr, m_op, m_len);
          m_len = 0;
          if (cur.halt) m_mode = M_HALT;
          else if (m_single || !r) m_mode = M_IDLE;
          else push_fetch();
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string ph);
    int eu; logic [16:0] ecw; bit ed;
    eu = 0; ecw = IDLE_WORD; ed = 1'b0;
    if (m_mode == M_EXEC) begin
      eu = m_q[0].upc; ecw = word_of[eu]; ed = m_q[0].last;
    end else if (m_mode == M_HALT) begin
      eu = 20;
    end
    check_val({ph, ".upc"}, 32'(upc), 32'(eu));
    check_val({ph, ".cw"}, 32'(cw), 32'(ecw));
    check_val({ph, ".done"}, 32'(instr_done), 32'(ed));
    check_val({ph, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
    check_val({ph, ".illegal"}, 32'(illegal), 32'(m_illegal));
  endtask

  // Called and returns at posedge+1
  task automatic do_cycle(input logic r, input logic s, input logic [3:0] op, input string ph);
    run = r; step = s; ir_opcode = op;
    @(posedge clk);
    model_advance(r, s, op);
    #1;
    check_all(ph);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({ph, ".async_rst"});
    @(posedge clk);
    #1;
    check_all({ph, ".rst"});
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0; n_bad = 0; n_instr = 0; m_op = 4'h0;
    init_words();
    model_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; ir_opcode = 4'h0;
    @(posedge clk);
    #1;
    do_reset("por");

    // 1: LDA under run
    for (int i = 0; i < 7; i++) do_cycle(1, 0, 4'h0, "lda");
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 4'h0, "lda_idle");

    // 2: ADD then SUB back-to-back
    for (int i = 0; i < 9; i++) do_cycle(1, 0, 4'h1, "add");
    for (int i = 0; i < 9; i++) do_cycle(1, 0, 4'h2, "sub");
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 4'h0, "sub_idle");

    // 3: single-step OUT, extra step mid-instruction ignored
    do_cycle(0, 1, 4'hE, "out");
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 4'hE, "out");
    do_cycle(0, 1, 4'hE, "out_step2");
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 4'hE, "out");

    // 4: HLT, then frozen despite run/step activity, then reset
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 4'hF, "hlt");
    for (int i = 0; i < 20; i++) do_cycle(i[0], i[1], 4'(i), "halted");
    do_reset("hlt");

    // 5: unmapped opcode -> NOP, sticky illegal
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 4'h7, "nop");
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 4'h0, "nop_idle");
    for (int i = 0; i < 7; i++) do_cycle(1, 0, 4'h0, "lda2");
    do_cycle(0, 0, 4'h0, "lda2_idle");
    do_reset("ill");

    // 6a: drop run at upc=8
    for (int i = 0; i < 6; i++) do_cycle(1, 0, 4'h1, "add_drop");
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 4'h1, "add_drop");
    // 6b: reset while at upc=9
    for (int i = 0; i < 7; i++) do_cycle(1, 0, 4'h1, "add_rst");
    do_reset("mid");
    do_cycle(0, 0, 4'h0, "post_rst");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic r, s;
      logic [3:0] op;
      r  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      op = 4'($urandom_range(0, 15));
      if (m_mode == M_HALT && $urandom_range(0, 5) == 0) do_reset("rnd");
      else if ($urandom_range(0, 249) == 0) do_reset("rnd");
      else do_cycle(r, s, op, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
